// File: rtl/input_channel.sv
// Wormhole mesh switch input channel: flit FIFO, XY routing of head flits, per-packet request hold.
// Defining IC_PROTO_ERR_CNT_EN adds err_cnt_o, a saturating count of dropped malformed flits.
module input_channel #(
  parameter int DATA_W         = 10,
  parameter int OUT_N          = 5,
  parameter int BUFFER_DEPTH_W = 2,
  parameter int X_W            = 2,
  parameter int Y_W            = 2,
  parameter int COL_CORD       = 0,
  parameter int ROW_CORD       = 0
`ifdef IC_PROTO_ERR_CNT_EN
  , parameter int ERR_CNT_W    = 8
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [OUT_N-1:0]  req_o,
  input  logic [OUT_N-1:0]  grant_i,
  input  logic [OUT_N-1:0]  oc_rdy_i,
  output logic              data_vld_o,
  output logic              flit_id_is_tail_o,
  output logic [DATA_W-1:0] data_o,
  output logic              state_o
`ifdef IC_PROTO_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam int DEPTH = 2 ** BUFFER_DEPTH_W;
  localparam logic [BUFFER_DEPTH_W:0] DEPTH_CNT = (BUFFER_DEPTH_W + 1)'(DEPTH);

  localparam logic [1:0] ID_HEAD   = 2'b10;
  localparam logic [1:0] ID_TAIL   = 2'b01;
  localparam logic [1:0] ID_SINGLE = 2'b11;

  localparam int IDX_L = 0;
  localparam int IDX_N = 1;
  localparam int IDX_E = 2;
  localparam int IDX_S = 3;
  localparam int IDX_W = 4;

  localparam logic [X_W-1:0] COL = X_W'(COL_CORD);
  localparam logic [Y_W-1:0] ROW = Y_W'(ROW_CORD);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]         mem_q [DEPTH];
  logic [BUFFER_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUFFER_DEPTH_W:0]   count_q;
  logic                      full, empty, push, pop;

  logic [DATA_W-1:0] head_flit;
  logic [1:0]        head_id;
  logic              head_starts_pkt, head_ends_pkt, xfer;
  logic [X_W-1:0]    dest_x;
  logic [Y_W-1:0]    dest_y;
  logic [OUT_N-1:0]  route_q, route_d, xy_oh;

  // Handshakes: upstream push = vld_i & rdy_o, rdy_o depends on occupancy only;
  // downstream transfer = data_vld_o & grant_i[route] & oc_rdy_i[route], all sampled at posedge.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign rdy_o = !full;
  assign push  = vld_i & rdy_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Flit storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_flit       = mem_q[rd_ptr_q];
  assign head_id         = head_flit[DATA_W-1 -: 2];
  assign head_starts_pkt = (head_id == ID_HEAD) || (head_id == ID_SINGLE);
  assign head_ends_pkt   = (head_id == ID_TAIL) || (head_id == ID_SINGLE);
  assign dest_x          = head_flit[X_W-1:0];
  assign dest_y          = head_flit[X_W+Y_W-1:X_W];

  // Dimension-ordered routing: resolve the column first, then the row.
  always_comb begin
    xy_oh = '0;
    if (dest_x > COL)      xy_oh[IDX_E] = 1'b1;
    else if (dest_x < COL) xy_oh[IDX_W] = 1'b1;
    else if (dest_y > ROW) xy_oh[IDX_S] = 1'b1;
    else if (dest_y < ROW) xy_oh[IDX_N] = 1'b1;
    else                   xy_oh[IDX_L] = 1'b1;
  end

  assign xfer = (state_q == ACTIVE) && !empty && |(route_q & grant_i & oc_rdy_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // The head flit stays buffered when IDLE accepts it; it leaves as the first transfer in ACTIVE,
  // so any later HEAD id inside the packet is simply forwarded like a body flit.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_starts_pkt) begin
            route_d = xy_oh;
            state_d = ACTIVE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (xfer) begin
          pop = 1'b1;
          if (head_ends_pkt) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_o             = (state_q == ACTIVE) ? route_q : '0;
  assign data_vld_o        = (state_q == ACTIVE) && !empty;
  assign flit_id_is_tail_o = head_ends_pkt;
  assign data_o            = head_flit;
  assign state_o           = state_q;

`ifdef IC_PROTO_ERR_CNT_EN
  logic                 malformed;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign malformed = (state_q == IDLE) && !empty && !head_starts_pkt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                              err_cnt_q <= '0;
    else if (malformed && (err_cnt_q != '1))  err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_o));
  a_pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ACTIVE && state_d == ACTIVE) |=> $stable(req_o));

endmodule

// File: tb/tb_input_channel.sv
// Bench for input_channel (COL_CORD=1, ROW_CORD=1): directed scenarios plus random packet traffic
// checked against a flit-queue reference model.
module tb_input_channel;

  localparam int DATA_W = 10;
  localparam int OUT_N  = 5;
  localparam int DEPTH  = 4;
  localparam int COL    = 1;
  localparam int ROW    = 1;
  localparam int ERR_MAX = 255;
  localparam logic [OUT_N-1:0] ALL1 = 5'b11111;
  localparam logic [OUT_N-1:0] NONE = 5'b00000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              vld_i = 1'b0;
  logic              rdy_o;
  logic [OUT_N-1:0]  req_o;
  logic [OUT_N-1:0]  grant_i = '0;
  logic [OUT_N-1:0]  oc_rdy_i = '0;
  logic              data_vld_o;
  logic              flit_id_is_tail_o;
  logic [DATA_W-1:0] data_o;
  logic              state;
`ifdef IC_PROTO_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  input_channel #(
    .DATA_W(DATA_W), .OUT_N(OUT_N), .BUFFER_DEPTH_W(2), .X_W(2), .Y_W(2),
    .COL_CORD(COL), .ROW_CORD(ROW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .req_o(req_o), .grant_i(grant_i), .oc_rdy_i(oc_rdy_i), .data_vld_o(data_vld_o),
    .flit_id_is_tail_o(flit_id_is_tail_o), .data_o(data_o), .state_o(state)
`ifdef IC_PROTO_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: buffered flits, packet-open flag, chosen output, error count.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mdl_out_q[$];
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] rx_q[$];
  bit m_active;
  int m_route;
  int m_err;
  int vectors;
  int miscompares;

  function automatic int xy_route(input logic [DATA_W-1:0] f);
    int dx = int'(f[1:0]);
    int dy = int'(f[3:2]);
    if (dx > COL) return 2;
    if (dx < COL) return 4;
    if (dy > ROW) return 3;
    if (dy < ROW) return 1;
    return 0;
  endfunction

  function automatic logic [OUT_N-1:0] mdl_req();
    logic [OUT_N-1:0] one = 5'b00001;
    return m_active ? (one << m_route) : NONE;
  endfunction

  function automatic bit is_tail_id(input logic [DATA_W-1:0] f);
    return (f[DATA_W-1 -: 2] == 2'b01) || (f[DATA_W-1 -: 2] == 2'b11);
  endfunction

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d,
                            input logic [OUT_N-1:0] g, input logic [OUT_N-1:0] r);
    bit push = v && (exp_q.size() < DEPTH);
    logic [DATA_W-1:0] f;
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      if (m_active) begin
        if (g[m_route] && r[m_route]) begin
          mdl_out_q.push_back(exp_q.pop_front());
          if (is_tail_id(f)) m_active = 0;
        end
      end else if (f[DATA_W-1 -: 2] == 2'b10 || f[DATA_W-1 -: 2] == 2'b11) begin
        m_active = 1;
        m_route  = xy_route(f);
      end else begin
        void'(exp_q.pop_front());
        if (m_err < ERR_MAX) m_err++;
      end
    end
    if (push) exp_q.push_back(d);
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic [OUT_N-1:0] g, input logic [OUT_N-1:0] r);
    vld_i = v; data_i = d; grant_i = g; oc_rdy_i = r;
    @(posedge clk);
    model_edge(v, d, g, r);
    #1;
  endtask

  // Driver: offers tx_q head upstream, logs flits the downstream handshake accepts.
  task automatic cycle(input logic [OUT_N-1:0] g, input logic [OUT_N-1:0] r, input bit rnd_vld);
    logic v = (tx_q.size() > 0) && (!rnd_vld || $urandom_range(0, 3) != 0);
    logic [DATA_W-1:0] d = (tx_q.size() > 0) ? tx_q[0] : '0;
    bit acc = v && rdy_o;
    if (data_vld_o && |(req_o & g & r)) rx_q.push_back(data_o);
    step(v, d, g, r);
    if (acc) void'(tx_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld_i = 1'b0; grant_i = '0; oc_rdy_i = '0;
    @(posedge clk);
    exp_q.delete(); mdl_out_q.delete(); tx_q.delete(); rx_q.delete();
    m_active = 0; m_route = 0; m_err = 0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL reset_req got=%b exp=%b", req_o, NONE); end
    vectors++; if (data_vld_o !== 1'b0) begin miscompares++; $display("FAIL reset_vld got=%b exp=0", data_vld_o); end
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got=%b exp=1", rdy_o); end
    vectors++; if (state !== 1'b0) begin miscompares++; $display("FAIL reset_state got=%b exp=0", state); end
`ifdef IC_PROTO_ERR_CNT_EN
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
`endif
  endtask

  task automatic test_multi_flit();
    logic [DATA_W-1:0] pkt[3] = '{10'b10_0000_0011, 10'b00_1010_1010, 10'b01_0101_0101};
    bit tail_seen = 0;
    do_reset();
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    for (int c = 1; c <= 10; c++) begin
      cycle(ALL1, ALL1, 0);
      if (c >= 2 && rx_q.size() < 3) begin
        vectors++;
        if (req_o !== 5'b00100) begin miscompares++; $display("FAIL multi_req c=%0d got=%b exp=00100", c, req_o); end
      end else if (rx_q.size() == 3 && !tail_seen) begin
        tail_seen = 1;
        vectors++;
        if (req_o !== NONE) begin miscompares++; $display("FAIL multi_req_after_tail got=%b exp=00000", req_o); end
      end
    end
    vectors++; if (rx_q.size() != 3) begin miscompares++; $display("FAIL multi_count got=%0d exp=3", rx_q.size()); end
    foreach (pkt[i]) begin
      vectors++;
      if (i < rx_q.size() && rx_q[i] !== pkt[i]) begin
        miscompares++; $display("FAIL multi_flit%0d got=%b exp=%b", i, rx_q[i], pkt[i]);
      end
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] f = 10'b11_0000_0101;
    do_reset();
    tx_q.push_back(f);
    cycle(ALL1, ALL1, 0);
    cycle(ALL1, ALL1, 0);
    vectors++; if (req_o !== 5'b00001) begin miscompares++; $display("FAIL single_req got=%b exp=00001", req_o); end
    vectors++; if (flit_id_is_tail_o !== 1'b1) begin miscompares++; $display("FAIL single_tail got=%b exp=1", flit_id_is_tail_o); end
    vectors++; if (data_vld_o !== 1'b1) begin miscompares++; $display("FAIL single_vld got=%b exp=1", data_vld_o); end
    vectors++; if (state !== 1'b1) begin miscompares++; $display("FAIL single_state got=%b exp=1", state); end
    cycle(ALL1, ALL1, 0);
    vectors++; if (rx_q.size() != 1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", rx_q.size()); end
    vectors++; if (rx_q.size() > 0 && rx_q[0] !== f) begin miscompares++; $display("FAIL single_flit got=%b exp=%b", rx_q[0], f); end
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL single_req_after got=%b exp=00000", req_o); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] pkt[4] = '{10'b10_0000_0011, 10'b00_0000_0001, 10'b00_0000_0010, 10'b01_0000_0011};
    do_reset();
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    for (int c = 1; c <= 4; c++) begin
      cycle(NONE, ALL1, 0);
      vectors++;
      if (rdy_o !== (c < 4)) begin miscompares++; $display("FAIL bp_rdy_fill c=%0d got=%b exp=%b", c, rdy_o, c < 4); end
    end
    for (int c = 0; c < 3; c++) begin
      cycle(NONE, ALL1, 0);
      vectors++; if (data_o !== pkt[0]) begin miscompares++; $display("FAIL bp_hold_data got=%b exp=%b", data_o, pkt[0]); end
      vectors++; if (rdy_o !== 1'b0) begin miscompares++; $display("FAIL bp_hold_rdy got=%b exp=0", rdy_o); end
    end
    cycle(ALL1, ALL1, 0);
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_after_pop got=%b exp=1", rdy_o); end
    vectors++; if (data_o !== pkt[1]) begin miscompares++; $display("FAIL bp_next_data got=%b exp=%b", data_o, pkt[1]); end
    for (int c = 0; c < 6; c++) cycle(ALL1, ALL1, 0);
    vectors++; if (rx_q.size() != 4) begin miscompares++; $display("FAIL bp_count got=%0d exp=4", rx_q.size()); end
    foreach (pkt[i]) begin
      vectors++;
      if (i < rx_q.size() && rx_q[i] !== pkt[i]) begin
        miscompares++; $display("FAIL bp_flit%0d got=%b exp=%b", i, rx_q[i], pkt[i]);
      end
    end
  endtask

  task automatic test_malformed();
    int n = 0;
    do_reset();
    tx_q.push_back(10'b00_1111_0000);
    cycle(ALL1, ALL1, 0);
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL mal_req0 got=%b exp=00000", req_o); end
    cycle(ALL1, ALL1, 0);
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL mal_req1 got=%b exp=00000", req_o); end
    cycle(ALL1, ALL1, 0);
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL mal_req2 got=%b exp=00000", req_o); end
    vectors++; if (data_vld_o !== 1'b0) begin miscompares++; $display("FAIL mal_vld got=%b exp=0", data_vld_o); end
`ifdef IC_PROTO_ERR_CNT_EN
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL mal_err1 got=%0d exp=1", err_cnt); end
`endif
    for (int i = 0; i < 259; i++) tx_q.push_back({1'b0, 1'($urandom), 8'($urandom)});
    while ((tx_q.size() > 0 || exp_q.size() > 0) && n < 1000) begin
      cycle(ALL1, ALL1, 0);
      n++;
      vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL mal_stream_req n=%0d got=%b exp=00000", n, req_o); end
    end
    vectors++; if (n >= 1000) begin miscompares++; $display("FAIL mal_timeout got=%0d cycles exp=<1000", n); end
    cycle(ALL1, ALL1, 0);
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL mal_rdy got=%b exp=1", rdy_o); end
`ifdef IC_PROTO_ERR_CNT_EN
    vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL mal_err_sat got=%0d exp=255", err_cnt); end
`endif
  endtask

  task automatic test_oc_rdy_toggle();
    logic [DATA_W-1:0] pkt[6];
    int n = 0;
    do_reset();
    pkt[0] = 10'b10_0000_1101;
    for (int i = 1; i < 5; i++) pkt[i] = {2'b00, 8'($urandom)};
    pkt[5] = {2'b01, 8'($urandom)};
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    for (int c = 0; c < 6; c++) begin
      cycle(5'b10111, ALL1, 0);
      vectors++; if (data_o !== pkt[0]) begin miscompares++; $display("FAIL tog_wrong_grant_data c=%0d got=%b exp=%b", c, data_o, pkt[0]); end
    end
    vectors++; if (req_o !== 5'b01000) begin miscompares++; $display("FAIL tog_req got=%b exp=01000", req_o); end
    while ((tx_q.size() > 0 || exp_q.size() > 0 || m_active) && n < 60) begin
      cycle(5'b01000, (n % 2 == 0) ? ALL1 : 5'b10111, 0);
      n++;
      if (exp_q.size() > 0) begin
        vectors++; if (data_o !== exp_q[0]) begin miscompares++; $display("FAIL tog_data n=%0d got=%b exp=%b", n, data_o, exp_q[0]); end
      end
    end
    vectors++; if (n >= 60) begin miscompares++; $display("FAIL tog_timeout got=%0d cycles exp=<60", n); end
    vectors++; if (rx_q.size() != 6) begin miscompares++; $display("FAIL tog_count got=%0d exp=6", rx_q.size()); end
    foreach (pkt[i]) begin
      vectors++;
      if (i < rx_q.size() && rx_q[i] !== pkt[i]) begin
        miscompares++; $display("FAIL tog_flit%0d got=%b exp=%b", i, rx_q[i], pkt[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] s = 10'b11_0000_0110;
    do_reset();
    tx_q.push_back(10'b10_0000_0000);
    tx_q.push_back(10'b00_0000_0001);
    tx_q.push_back(10'b00_0000_0010);
    tx_q.push_back(10'b01_0000_0011);
    cycle(NONE, ALL1, 0);
    cycle(NONE, ALL1, 0);
    vectors++; if (req_o !== 5'b10000) begin miscompares++; $display("FAIL rmid_req_w got=%b exp=10000", req_o); end
    do_reset();
    vectors++; if (req_o !== NONE) begin miscompares++; $display("FAIL rmid_req got=%b exp=00000", req_o); end
    vectors++; if (data_vld_o !== 1'b0) begin miscompares++; $display("FAIL rmid_vld got=%b exp=0", data_vld_o); end
    vectors++; if (rdy_o !== 1'b1) begin miscompares++; $display("FAIL rmid_rdy got=%b exp=1", rdy_o); end
    tx_q.push_back(s);
    cycle(ALL1, ALL1, 0);
    cycle(ALL1, ALL1, 0);
    vectors++; if (req_o !== 5'b00100) begin miscompares++; $display("FAIL rmid_new_req got=%b exp=00100", req_o); end
    cycle(ALL1, ALL1, 0);
    vectors++; if (rx_q.size() != 1 || rx_q[0] !== s) begin miscompares++; $display("FAIL rmid_new_flit count=%0d exp=1 flit %b", rx_q.size(), s); end
  endtask

  task automatic test_random_traffic();
    int n = 0;
    logic [OUT_N-1:0] g, r;
    do_reset();
    for (int p = 0; p < 60; p++) begin
      int kind = $urandom_range(0, 7);
      logic [3:0] dst = 4'($urandom);
      if (kind == 0) begin
        tx_q.push_back({1'b0, 1'($urandom), 8'($urandom)});
      end else if (kind == 1) begin
        tx_q.push_back({2'b11, 4'($urandom), dst});
      end else begin
        int nb = $urandom_range(0, 3);
        tx_q.push_back({2'b10, 4'($urandom), dst});
        for (int b = 0; b < nb; b++) tx_q.push_back({2'b00, 8'($urandom)});
        tx_q.push_back({2'b01, 8'($urandom)});
      end
    end
    while ((tx_q.size() > 0 || exp_q.size() > 0 || m_active) && n < 5000) begin
      g = ($urandom_range(0, 1) == 1) ? ALL1 : 5'($urandom);
      r = ($urandom_range(0, 2) != 0) ? ALL1 : 5'($urandom);
      cycle(g, r, 1);
      n++;
      vectors++; if (rdy_o !== (exp_q.size() < DEPTH)) begin miscompares++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, rdy_o, exp_q.size() < DEPTH); end
      vectors++; if (req_o !== mdl_req()) begin miscompares++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, req_o, mdl_req()); end
      vectors++; if (data_vld_o !== (m_active && exp_q.size() > 0)) begin miscompares++; $display("FAIL rnd_vld n=%0d got=%b", n, data_vld_o); end
      if (exp_q.size() > 0) begin
        vectors++; if (data_o !== exp_q[0]) begin miscompares++; $display("FAIL rnd_data n=%0d got=%b exp=%b", n, data_o, exp_q[0]); end
        if (m_active) begin
          vectors++; if (flit_id_is_tail_o !== is_tail_id(exp_q[0])) begin miscompares++; $display("FAIL rnd_tail n=%0d got=%b exp=%b", n, flit_id_is_tail_o, is_tail_id(exp_q[0])); end
        end
      end
`ifdef IC_PROTO_ERR_CNT_EN
      vectors++; if (err_cnt !== 8'(m_err)) begin miscompares++; $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, err_cnt, m_err); end
`endif
    end
    vectors++; if (n >= 5000) begin miscompares++; $display("FAIL rnd_timeout got=%0d cycles exp=<5000", n); end
    vectors++; if (rx_q.size() != mdl_out_q.size()) begin miscompares++; $display("FAIL rnd_count got=%0d exp=%0d", rx_q.size(), mdl_out_q.size()); end
    foreach (mdl_out_q[i]) begin
      if (i < rx_q.size()) begin
        vectors++;
        if (rx_q[i] !== mdl_out_q[i]) begin miscompares++; $display("FAIL rnd_flit%0d got=%b exp=%b", i, rx_q[i], mdl_out_q[i]); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_multi_flit();
    test_single();
    test_backpressure();
    test_malformed();
    test_oc_rdy_toggle();
    test_reset_mid_packet();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
